mdu_multicycle: RTL and testbench
=================================

// Module: mdu_multicycle
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair.
//  It is the next-generation CPU datapath's replacement for single-cycle arithmetic.
//  The execute stage issues an op with a one-cycle start pulse and stalls while start|busy.
//  Results appear on hi/lo after a configurable latency.
//  Adds MADD accumulate, flush-cancel and defined divide-by-zero/overflow results.
// PARAMETERS
//  WIDTH        32  operand and HI/LO width
//  MULT_CYCLES  5   busy cycles for MULT/MULTU/MADD (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk     in   1      rising-edge clock
//  reset   in   1      asynchronous, active-low; 0 clears all state
//  start   in   1      issue op this cycle; only accepted when busy==0
//  op      in   3      0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MADD,6 MTHI,7 MTLO
//  a       in   WIDTH  operand rs
//  b       in   WIDTH  operand rt
//  flush   in   1      cancel in-flight op (pipeline exception/flush)
//  busy    out  1      registered; high while a mult/div is in flight
//  done    out  1      one-cycle pulse: hi/lo just took a mult/div result
//  hi      out  WIDTH  HI register (MFHI source)
//  lo      out  WIDTH  LO register (MFLO source)
// BEHAVIOUR
//  Reset (reset==0, any time, async): hi=0, lo=0, busy=0, done=0, state=IDLE.
//    Counter and latched operands/results are also cleared.
//  FSM states IDLE, MUL_RUN, DIV_RUN:
//    IDLE + start + op in{1,2,5} -> MUL_RUN, count=MULT_CYCLES.
//    IDLE + start + op in{3,4}   -> DIV_RUN, count=DIV_CYCLES.
//    Operands are latched and the result is computed into a pending register at accept.
//    RUN: count decrements each cycle; on the edge where count reaches 0:
//      hi/lo <= pending, busy<=0, done<=1 for one cycle, state -> IDLE.
//  Timing: start accepted at edge E0; busy=1 for cycles after E0 .. E0+N-1.
//    hi/lo/done update at edge E0+N (N = MULT_CYCLES or DIV_CYCLES).
//  MTHI/MTLO (op 6/7) in IDLE: hi<=a or lo<=a at the next edge, no busy, no done.
//  start while busy==1 (any op): ignored; the issuing stage must not do this, and the bench checks it is harmless.
//  NOP or start==0: no state change.
//  Arithmetic:
//    MULT: signed 2W product; {hi,lo} <= a*b.
//    MULTU: unsigned 2W product; {hi,lo} <= a*b.
//    MADD: {hi,lo} <= {hi,lo} + signed(a*b), mod 2^(2W).
//      Uses the hi/lo values at accept time.
//    DIV: lo <= a/b, hi <= a%b, signed, truncating toward zero; remainder takes the sign of a.
//    DIVU: same, unsigned.
//    b==0 (DIV or DIVU): lo <= all ones, hi <= a.
//    DIV overflow (a==MIN, b==-1): lo <= MIN, hi <= 0.
//  flush==1:
//    In RUN: abort; next edge busy=0, state IDLE, hi/lo unchanged, no done.
//    In IDLE: suppresses a same-cycle start, including MTHI/MTLO.
//  Simultaneous count==0 and flush: flush wins; the result is discarded.
//  Simultaneous done and new start: busy is already 0 in the done cycle, so the start is accepted there.
//    Back-to-back throughput is one op per N+1 cycles.
// TESTING
//  1. Hold reset=0 mid-MULT (busy=1) -> busy, hi, lo, done all 0 immediately.
//     After release, IDLE; start is accepted.
//  2. MULT a=0xFFFFFFFE(-2), b=3 -> busy high for 5 cycles.
//     Then hi=0xFFFFFFFF, lo=0xFFFFFFFA, with a 1-cycle done.
//  3. DIVU a=7, b=2 -> after 10 cycles lo=3, hi=1.
//     Also DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  4. DIV b=0, a=0x1234 -> lo=0xFFFFFFFF, hi=0x1234.
//     Also DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
//  5. MTHI 5, MTLO 6, then MADD a=2, b=3 -> hi=5, lo=12 after 5 cycles.
//     Also start MULTU while busy -> ignored; result unchanged.
//  6. DIV issued, flush at busy cycle 4 -> busy low next cycle, hi/lo keep prior values, no done.
//     Also flush at the final count -> same.

Source files
------------

// File: rtl/mdu_multicycle.sv
// Multi-cycle MULT/MULTU/MADD/DIV/DIVU unit owning HI/LO; results land MULT_CYCLES/DIV_CYCLES edges after accept.
// No ready handshake: start is ignored while busy, flush aborts an in-flight op and suppresses a same-cycle start.
module mdu_multicycle #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MADD  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_MUL_RUN, S_DIV_RUN} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } hilo_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  hilo_t           pend_q, pend_d;
  hilo_t           hilo_q, hilo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            accept, is_mul, is_div, finish;
  hilo_t           res;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   a_mag, b_mag, uq, ur, mq, mr;

  assign accept = start && !flush && (state_q == S_IDLE);
  assign is_mul = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD);
  assign is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign finish = ((state_q == S_MUL_RUN) || (state_q == S_DIV_RUN)) &&
                  (count_q == ONE) && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      pend_q  <= '0;
      hilo_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      hilo_q  <= hilo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (accept && is_mul) begin
          state_d = S_MUL_RUN;
          count_d = MULT_N;
        end else if (accept && is_div) begin
          state_d = S_DIV_RUN;
          count_d = DIV_N;
        end
      end
      S_MUL_RUN, S_DIV_RUN: begin
        if (flush || count_q == ONE) begin
          state_d = S_IDLE;
          count_d = '0;
        end else begin
          count_d = count_q - ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  // Result is fully computed at accept; the RUN states only model latency.
  always_comb begin
    prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    a_mag  = a[WIDTH-1] ? -a : a;
    b_mag  = b[WIDTH-1] ? -b : b;
    uq = '0;
    ur = '0;
    mq = '0;
    mr = '0;
    if (b != '0) begin
      uq = a / b;
      ur = a % b;
      mq = a_mag / b_mag;
      mr = a_mag % b_mag;
    end
    res = hilo_q;
    case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_MADD:  res = hilo_q + prod_s;
      OP_DIV: begin
        if (b == '0) begin
          res.hi = a;
          res.lo = {WIDTH{1'b1}};
        end else if (a == MIN && b == {WIDTH{1'b1}}) begin
          res.hi = '0;
          res.lo = MIN;
        end else begin
          res.hi = a[WIDTH-1] ? -mr : mr;
          res.lo = (a[WIDTH-1] ^ b[WIDTH-1]) ? -mq : mq;
        end
      end
      OP_DIVU: begin
        if (b == '0) begin
          res.hi = a;
          res.lo = {WIDTH{1'b1}};
        end else begin
          res.hi = ur;
          res.lo = uq;
        end
      end
      default: res = hilo_q;
    endcase
  end

  always_comb begin
    hilo_d = hilo_q;
    pend_d = pend_q;
    busy_d = (state_d != S_IDLE);
    done_d = 1'b0;
    if (accept) begin
      if (op == OP_MTHI) hilo_d.hi = a;
      else if (op == OP_MTLO) hilo_d.lo = a;
      else if (is_mul || is_div) pend_d = res;
    end
    if (finish) begin
      hilo_d = pend_q;
      done_d = 1'b1;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hilo_q.hi;
  assign lo   = hilo_q.lo;

endmodule

// File: tb/tb_mdu_multicycle.sv
// Randomized and directed bench for mdu_multicycle against a plain-arithmetic HI/LO model.
module tb_mdu_multicycle;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_multicycle dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic void model_calc(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] eh, output logic [31:0] el);
    longint sx, sy, q, r;
    logic [63:0] acc;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    acc = {m_hi, m_lo};
    case (o)
      3'd1: acc = 64'(sx * sy);
      3'd2: acc = {32'd0, x} * {32'd0, y};
      3'd5: acc = {m_hi, m_lo} + 64'(sx * sy);
      3'd3: begin
        if (y == 0) acc = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) acc = {32'd0, 32'h8000_0000};
        else begin
          q = sx / sy;
          r = sx % sy;
          acc = {32'(r), 32'(q)};
        end
      end
      3'd4: begin
        if (y == 0) acc = {x, 32'hFFFF_FFFF};
        else acc = {x % y, x / y};
      end
      default: acc = {m_hi, m_lo};
    endcase
    eh = acc[63:32];
    el = acc[31:0];
  endfunction

  // Called at a negedge; issues the op there and returns at the negedge right after completion/abort.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int flush_at, input int junk_at);
    int n;
    bit aborted;
    logic [31:0] eh, el, old_hi, old_lo;
    n = (o == 3'd3 || o == 3'd4) ? 10 : 5;
    model_calc(o, x, y, eh, el);
    old_hi = m_hi;
    old_lo = m_lo;
    aborted = 1'b0;
    start = 1'b1; op = o; a = x; b = y;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL busy_cycle op=%0d k=%0d: busy=%b done=%b, want busy=1 done=0", o, k, busy, done);
      end
      if (k == junk_at) begin
        start = 1'b1;
        op = 3'($urandom_range(1, 7));
        a = $urandom;
        b = $urandom;
      end
      if (k == flush_at) begin
        flush = 1'b1;
        aborted = 1'b1;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    checks++;
    if (aborted) begin
      if (busy !== 1'b0 || done !== 1'b0 || hi !== old_hi || lo !== old_lo) begin
        errors++;
        $display("FAIL flush_abort op=%0d: busy=%b done=%b hi=%h lo=%h, want 0 0 %h %h",
                 o, busy, done, hi, lo, old_hi, old_lo);
      end
    end else begin
      m_hi = eh;
      m_lo = el;
      if (busy !== 1'b0 || done !== 1'b1 || hi !== eh || lo !== el) begin
        errors++;
        $display("FAIL result op=%0d a=%h b=%h: busy=%b done=%b hi=%h lo=%h, want 0 1 %h %h",
                 o, x, y, busy, done, hi, lo, eh, el);
      end
    end
  endtask

  task automatic do_mt(input logic [2:0] o, input logic [31:0] x, input bit fl);
    start = 1'b1; op = o; a = x; flush = fl;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    if (!fl) begin
      if (o == 3'd6) m_hi = x;
      else m_lo = x;
    end
    checks++;
    if (hi !== m_hi || lo !== m_lo || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL move op=%0d flush=%0d: hi=%h lo=%h busy=%b done=%b, want %h %h 0 0",
               o, fl, hi, lo, busy, done, m_hi, m_lo);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
    end
    reset = 1'b1;
    @(negedge clk);
    do_mt(3'd6, 32'hDEAD_BEEF, 1'b0);
    do_mt(3'd7, 32'h1234_5678, 1'b0);
    start = 1'b1; op = 3'd1; a = $urandom; b = $urandom;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_mult: busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
    end
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op(3'd1, $urandom, $urandom, 0, 0);
  endtask

  task automatic test_mult;
    @(negedge clk);
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 0, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 0);
  endtask

  task automatic test_div;
    @(negedge clk);
    run_op(3'd4, 32'd7, 32'd2, 0, 0);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(3'd3, 32'd7, 32'hFFFF_FFFE, 0, 0);
    run_op(3'd3, 32'h0000_1234, 32'd0, 0, 0);
    run_op(3'd4, 32'h0000_4321, 32'd0, 0, 0);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
  endtask

  task automatic test_madd;
    @(negedge clk);
    do_mt(3'd6, 32'd5, 1'b0);
    do_mt(3'd7, 32'd6, 1'b0);
    run_op(3'd5, 32'd2, 32'd3, 0, 2);
    run_op(3'd5, 32'hFFFF_FFFF, 32'd100, 0, 4);
  endtask

  task automatic test_flush;
    @(negedge clk);
    run_op(3'd3, $urandom, $urandom, 4, 0);
    run_op(3'd3, $urandom, $urandom, 10, 0);
    run_op(3'd1, $urandom, $urandom, 5, 0);
    do_mt(3'd6, $urandom, 1'b1);
    do_mt(3'd7, $urandom, 1'b1);
    start = 1'b1; op = 3'd3; a = $urandom; b = $urandom; flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_start: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    run_op(3'd1, $urandom, $urandom, 0, 0);
    run_op(3'd4, $urandom, $urandom, 0, 0);
    run_op(3'd5, $urandom, $urandom, 0, 0);
    run_op(3'd3, $urandom, $urandom, 0, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random;
    logic [2:0] o;
    int n, fa, ja;
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(1, 7));
      if (o == 3'd6 || o == 3'd7) begin
        do_mt(o, pick(), ($urandom_range(0, 4) == 0));
      end else begin
        n = (o == 3'd3 || o == 3'd4) ? 10 : 5;
        fa = ($urandom_range(0, 4) == 0) ? $urandom_range(1, n) : 0;
        ja = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
        run_op(o, pick(), pick(), fa, ja);
      end
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_madd();
    test_flush();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
